syncram_arb2: RTL

- Two-requester round-robin arbiter that shares one single-port synchronous RAM (registered read, 1-cycle read latency, write-enable and address sampled on clk rising edge).
- Sits between two bus masters (e.g. CPU load/store unit and DMA/debug port) and the RAM instance.
- Grants one command per cycle, drives the RAM command bus and steers returning read data to the requester that issued it.

---
 rtl/syncram_arb2.sv | 122 ++++++++++++
 1 files changed

// File: rtl/syncram_arb2.sv
// Two-requester round-robin arbiter in front of one single-port synchronous RAM (1-cycle read latency).
// Optional exclusive-lock support for read-modify-write is enabled with `define SYNCRAM_ARB_LOCK_EN.
module syncram_arb2 #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [AWIDTH-1:0] addr0,
    input  logic [DWIDTH-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic              we1,
    input  logic [AWIDTH-1:0] addr1,
    input  logic [DWIDTH-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DWIDTH-1:0] rdata,
    output logic              ram_we,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_wdata,
`ifdef SYNCRAM_ARB_LOCK_EN
    input  logic              lock0,
    input  logic              lock1,
`endif
    input  logic [DWIDTH-1:0] ram_rdata
);

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

    req_id_t prio;
    logic    rtag_v;
    req_id_t rtag_id;
    logic    elig0;
    logic    elig1;
    logic    rd_gnt;

`ifdef SYNCRAM_ARB_LOCK_EN
    logic    lock_v;
    req_id_t lock_id;
    logic    owner_req;
    logic    owner_gnt;
    logic    owner_lock;

    // While locked, only the lock owner is eligible; prio is still honoured when it is the owner.
    assign elig0 = req0 & (~lock_v | (lock_id == REQ0));
    assign elig1 = req1 & (~lock_v | (lock_id == REQ1));

    assign owner_req  = (lock_id == REQ0) ? req0  : req1;
    assign owner_gnt  = (lock_id == REQ0) ? gnt0  : gnt1;
    assign owner_lock = (lock_id == REQ0) ? lock0 : lock1;
`else
    assign elig0 = req0;
    assign elig1 = req1;
`endif

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset_n) begin
            if (elig0 && elig1) begin
                if (prio == REQ1) gnt1 = 1'b1;
                else              gnt0 = 1'b1;
            end else if (elig0) begin
                gnt0 = 1'b1;
            end else if (elig1) begin
                gnt1 = 1'b1;
            end
        end
    end

    // With no grant the bus carries requester 0's fields; ram_we=0 makes them harmless.
    assign ram_we    = (gnt0 & we0) | (gnt1 & we1);
    assign ram_addr  = gnt1 ? addr1  : addr0;
    assign ram_wdata = gnt1 ? wdata1 : wdata0;
    assign rd_gnt    = (gnt0 & ~we0) | (gnt1 & ~we1);

    assign rvalid0 = rtag_v & (rtag_id == REQ0);
    assign rvalid1 = rtag_v & (rtag_id == REQ1);
    assign rdata   = ram_rdata;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio    <= REQ0;
            rtag_v  <= 1'b0;
            rtag_id <= REQ0;
        end else begin
            if (gnt0 || gnt1) prio <= gnt0 ? REQ1 : REQ0;
            rtag_v <= rd_gnt;
            if (rd_gnt) rtag_id <= gnt1 ? REQ1 : REQ0;
        end
    end

`ifdef SYNCRAM_ARB_LOCK_EN
    // A fresh lock grant takes precedence over the release test, which is written first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_v  <= 1'b0;
            lock_id <= REQ0;
        end else begin
            if (lock_v && (!owner_req || (owner_gnt && !owner_lock))) lock_v <= 1'b0;
            if (gnt0 && lock0) begin
                lock_v  <= 1'b1;
                lock_id <= REQ0;
            end
            if (gnt1 && lock1) begin
                lock_v  <= 1'b1;
                lock_id <= REQ1;
            end
        end
    end
`endif

endmodule
